// File: rtl/mc_chroma_ctrl_pkg.sv
// Shared definitions for the chroma interpolation controller.
// Holds the default block geometry, the Cb/Cr select encodings and
// the controller state encoding.
package mc_chroma_ctrl_pkg;

  localparam int CU_W_DEF  = 32;
  localparam int SUB_DEF   = 8;
  localparam int TAPS_DEF  = 4;
  localparam int CNT_W_DEF = 3;

  localparam logic MC_CHROMA_CB = 1'b0;
  localparam logic MC_CHROMA_CR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOAD,
    ST_FILT,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Reference rows needed to filter one sub-block.
  function automatic int rows_per_blk(input int sub, input int taps);
    return sub + taps - 1;
  endfunction

endpackage

// File: rtl/mc_chroma_ctrl_if.sv
// Handshake bundle between the chroma controller and its neighbours
// (MC sequencer, reference fetch unit, chroma filter datapath).
// slave  : the controller side
// master : the environment side (sequencer / fetch / filter)
interface mc_chroma_ctrl_if
  import mc_chroma_ctrl_pkg::*;
#(
  parameter int X_W = $clog2(CU_W_DEF)
);
  logic           chroma_start_i;
  logic           chroma_sel_i;
  logic           chroma_done_o;
  logic           busy_o;
  logic           fetch_req_o;
  logic           fetch_sel_o;
  logic [X_W-1:0] fetch_x_o;
  logic [X_W-1:0] fetch_y_o;
  logic           fetch_ack_i;
  logic           fetch_vld_i;
  logic           filt_start_o;
  logic           filt_done_i;

  modport slave (
    input  chroma_start_i, chroma_sel_i, fetch_ack_i, fetch_vld_i, filt_done_i,
    output chroma_done_o, busy_o, fetch_req_o, fetch_sel_o, fetch_x_o, fetch_y_o,
           filt_start_o
  );

  modport master (
    output chroma_start_i, chroma_sel_i, fetch_ack_i, fetch_vld_i, filt_done_i,
    input  chroma_done_o, busy_o, fetch_req_o, fetch_sel_o, fetch_x_o, fetch_y_o,
           filt_start_o
  );
endinterface

// File: rtl/mc_chroma_blk_cnt.sv
// Raster-order sub-block counter (column fastest), shared with the luma path.
// Ports: clk, rst (sync, active-high), clr (restart at 0,0), adv (step one
// sub-block), col/row (current indices), last (at bottom-right sub-block).
module mc_chroma_blk_cnt #(
  parameter int NB    = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(NB - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col == MAX_IDX) begin
        col <= '0;
        row <= (row == MAX_IDX) ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

  assign last = (col == MAX_IDX) && (row == MAX_IDX);

endmodule

// File: rtl/mc_chroma_ctrl.sv
// Chroma interpolation controller: on a start pulse walks the chroma block
// sub-block by sub-block, requesting reference rows, counting them in and
// kicking the chroma filter, then pulses done.
// Ports: clk, rst (sync, active-high), bus (mc_chroma_ctrl_if.slave) carrying
// the sequencer start/sel/done/busy, fetch req/ack/vld/x/y/sel and filter
// start/done signals.
module mc_chroma_ctrl
  import mc_chroma_ctrl_pkg::*;
#(
  parameter int CU_W  = CU_W_DEF,
  parameter int SUB   = SUB_DEF,
  parameter int TAPS  = TAPS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  mc_chroma_ctrl_if.slave bus
);

  localparam int NB     = CU_W / SUB;
  localparam int ROWS   = rows_per_blk(SUB, TAPS);
  localparam int RC_W   = $clog2(ROWS + 1);
  localparam int X_W    = $clog2(CU_W);
  localparam int SUB_SH = $clog2(SUB);

  state_t            state, state_nx;
  logic [RC_W-1:0]   rowcnt, rowcnt_nx;
  logic              sel_r;
  logic              first_r;
  logic              cnt_clr, cnt_adv;
  logic              last_blk;
  logic [CNT_W-1:0]  col, row;

  mc_chroma_blk_cnt #(
    .NB    (NB),
    .CNT_W (CNT_W)
  ) u_blk_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .adv  (cnt_adv),
    .col  (col),
    .row  (row),
    .last (last_blk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rowcnt  <= '0;
      sel_r   <= MC_CHROMA_CB;
      first_r <= 1'b0;
    end else begin
      state  <= state_nx;
      rowcnt <= rowcnt_nx;
      // The sequencer raises sel one cycle after start, so sel is captured
      // in the first REQ cycle of the pass and held for the whole block.
      if (state == ST_IDLE && bus.chroma_start_i) begin
        first_r <= 1'b1;
      end else if (state == ST_REQ) begin
        first_r <= 1'b0;
      end
      if (state == ST_REQ && first_r) begin
        sel_r <= bus.chroma_sel_i;
      end
    end
  end

  always_comb begin
    state_nx         = state;
    rowcnt_nx        = rowcnt;
    cnt_clr          = 1'b0;
    cnt_adv          = 1'b0;
    bus.fetch_req_o  = 1'b0;
    bus.filt_start_o = 1'b0;
    bus.chroma_done_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.chroma_start_i) begin
          state_nx  = ST_REQ;
          cnt_clr   = 1'b1;
          rowcnt_nx = '0;
        end
      end
      ST_REQ: begin
        bus.fetch_req_o = 1'b1;
        if (bus.fetch_ack_i) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.fetch_vld_i) begin
          if (rowcnt == RC_W'(ROWS - 1)) begin
            state_nx  = ST_FILT;
            rowcnt_nx = '0;
          end else begin
            rowcnt_nx = rowcnt + RC_W'(1);
          end
        end
      end
      ST_FILT: begin
        bus.filt_start_o = 1'b1;
        state_nx         = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.filt_done_i) state_nx = ST_NEXT;
      end
      ST_NEXT: begin
        // The counter is not stepped past the final sub-block so the fetch
        // origin keeps showing it while idle.
        if (last_blk) begin
          state_nx = ST_DONE;
        end else begin
          cnt_adv  = 1'b1;
          state_nx = ST_REQ;
        end
      end
      ST_DONE: begin
        bus.chroma_done_o = 1'b1;
        state_nx          = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.busy_o      = (state != ST_IDLE);
  // Pass sel straight through on the capture cycle so an immediate ack on
  // the very first request already sees the right component.
  assign bus.fetch_sel_o = first_r ? bus.chroma_sel_i : sel_r;
  assign bus.fetch_x_o   = X_W'(col) << SUB_SH;
  assign bus.fetch_y_o   = X_W'(row) << SUB_SH;

endmodule

// File: tb/tb_mc_chroma_ctrl.sv
module tb_mc_chroma_ctrl;
  import mc_chroma_ctrl_pkg::*;

  localparam int NB   = CU_W_DEF / SUB_DEF;
  localparam int ROWS = SUB_DEF + TAPS_DEF - 1;
  localparam int LAT  = 1 + NB * NB * (ROWS + 4);
  localparam int LIM  = 6000;

  typedef struct {
    int x;
    int y;
    int sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_drv = 1'b0;
  logic spur_start = 1'b0;

  always #5 clk = ~clk;

  mc_chroma_ctrl_if bus ();
  assign bus.chroma_start_i = start_drv | spur_start;

  mc_chroma_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t exp_q[$];
  int   done_q[$];
  int   exp_busy = 0;
  int   start_cyc = 0;
  int   pass_done = 0;
  int   hs_cnt = 0;
  int   filt_total = 0;

  int ack_dly = 0, vld_mode = 0, fd_dly = 1, spurious = 0;
  int rows_owed = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Fetch unit / filter responder.
  initial begin
    int fd_cnt, hs_pending, req_age, tog;
    logic ack_n, vld_n, fd_n;
    fd_cnt = 0; hs_pending = 0; req_age = 0; tog = 0;
    bus.fetch_ack_i = 1'b0; bus.fetch_vld_i = 1'b0; bus.filt_done_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        rows_owed = 0; fd_cnt = 0; hs_pending = 0; req_age = 0;
        ack_n = 1'b0; vld_n = 1'b0; fd_n = 1'b0; spur_start = 1'b0;
      end else begin
        if (hs_pending != 0) begin
          rows_owed  = ROWS;
          hs_pending = 0;
        end
        fd_n = 1'b0;
        if (fd_cnt > 0) begin
          fd_cnt--;
          if (fd_cnt == 0) fd_n = 1'b1;
        end else if (spurious != 0 && rows_owed > 0) begin
          fd_n = ($urandom % 4 == 0);
        end
        vld_n = 1'b0;
        if (rows_owed > 0) begin
          case (vld_mode)
            0: vld_n = 1'b1;
            1: begin tog = 1 - tog; vld_n = (tog == 1); end
            default: vld_n = ($urandom % 2 == 1);
          endcase
          if (vld_n) rows_owed--;
        end else if (spurious != 0) begin
          vld_n = ($urandom % 2 == 1);
        end
        ack_n = 1'b0;
        if (bus.fetch_req_o) begin
          if (req_age >= ack_dly) begin
            ack_n = 1'b1; hs_pending = 1; req_age = 0;
          end else begin
            req_age++;
          end
        end else begin
          req_age = 0;
        end
        spur_start = (spurious != 0) && (bus.fetch_req_o || rows_owed > 0) &&
                     ($urandom % 8 == 0);
        if (bus.filt_start_o) fd_cnt = fd_dly;
      end
      bus.fetch_ack_i = ack_n;
      bus.fetch_vld_i = vld_n;
      bus.filt_done_i = fd_n;
    end
  end

  // Monitor / scoreboard.
  initial begin
    int pend, px, py, psel, prev_done, filt_in_blk, e_lat;
    exp_t e;
    pend = 0; px = 0; py = 0; psel = 0; prev_done = 0; filt_in_blk = 0;
    forever begin
      @(posedge clk); #3;
      if (rst) begin
        pend = 0; prev_done = 0; filt_in_blk = 0;
      end else begin
        check("busy", int'(bus.busy_o), exp_busy);
        if (prev_done != 0) check("done_width", int'(bus.chroma_done_o), 0);
        if (pend != 0) begin
          check("req_hold", int'(bus.fetch_req_o), 1);
          check("x_hold", int'(bus.fetch_x_o), px);
          check("y_hold", int'(bus.fetch_y_o), py);
          check("sel_hold", int'(bus.fetch_sel_o), psel);
        end
        if (bus.fetch_req_o && bus.fetch_ack_i) begin
          hs_cnt++;
          filt_in_blk = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_req", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("fetch_x", int'(bus.fetch_x_o), e.x);
            check("fetch_y", int'(bus.fetch_y_o), e.y);
            check("fetch_sel", int'(bus.fetch_sel_o), e.sel);
          end
        end
        pend = (bus.fetch_req_o && !bus.fetch_ack_i) ? 1 : 0;
        px = int'(bus.fetch_x_o); py = int'(bus.fetch_y_o); psel = int'(bus.fetch_sel_o);
        if (bus.filt_start_o) begin
          check("filt_rows_left", rows_owed, 0);
          check("filt_once", filt_in_blk, 0);
          filt_in_blk++;
          filt_total++;
        end
        if (bus.chroma_done_o) begin
          if (done_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e_lat = done_q.pop_front();
            if (e_lat >= 0) check("latency", cyc - start_cyc, e_lat);
            check("reqs_left", exp_q.size(), 0);
            check("filt_total", filt_total, NB * NB);
          end
          exp_busy  = 0;
          pass_done = 1;
        end
        prev_done = int'(bus.chroma_done_o);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_pass(input int sel, input int sel0, input int lat_chk);
    exp_t e;
    for (int r = 0; r < NB; r++)
      for (int c = 0; c < NB; c++) begin
        e.x = c * SUB_DEF; e.y = r * SUB_DEF; e.sel = sel;
        exp_q.push_back(e);
      end
    done_q.push_back(lat_chk != 0 ? LAT : -1);
    pass_done = 0; hs_cnt = 0; filt_total = 0;
    bus.chroma_sel_i = sel0[0];
    start_drv = 1'b1;
    start_cyc = cyc;
    step();
    start_drv = 1'b0;
    bus.chroma_sel_i = sel[0];
    exp_busy = 1;
  endtask

  task automatic flush_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete(); done_q.delete();
    exp_busy = 0; hs_cnt = 0; filt_total = 0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < LIM && pass_done == 0; n++) step();
    if (pass_done == 0) begin
      check("done_timeout", 0, 1);
      flush_reset();
    end else begin
      check("idle_req", int'(bus.fetch_req_o), 0);
      check("idle_x", int'(bus.fetch_x_o), (NB - 1) * SUB_DEF);
      check("idle_y", int'(bus.fetch_y_o), (NB - 1) * SUB_DEF);
    end
  endtask

  task automatic run_pass(input int sel, input int sel0, input int lat_chk);
    start_pass(sel, sel0, lat_chk);
    wait_done();
    repeat (3) step();
  endtask

  task automatic set_knobs(input int a, input int v, input int f, input int s);
    ack_dly = a; vld_mode = v; fd_dly = f; spurious = s;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(bus.busy_o), 0);
    check({tag, "_req"}, int'(bus.fetch_req_o), 0);
    check({tag, "_x"}, int'(bus.fetch_x_o), 0);
    check({tag, "_y"}, int'(bus.fetch_y_o), 0);
    check({tag, "_sel"}, int'(bus.fetch_sel_o), 0);
    check({tag, "_done"}, int'(bus.chroma_done_o), 0);
    check({tag, "_filt"}, int'(bus.filt_start_o), 0);
  endtask

  initial begin
    int s;
    bus.chroma_sel_i = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("rst0");
    rst = 1'b0;
    repeat (2) step();

    // Basic Cb with immediate responses.
    set_knobs(0, 0, 1, 0);
    run_pass(int'(MC_CHROMA_CB), int'(MC_CHROMA_CB), 1);

    // Cr with sel raised only after the start cycle.
    run_pass(int'(MC_CHROMA_CR), int'(MC_CHROMA_CB), 1);

    // Backpressure on ack, toggling vld, slow filter.
    set_knobs(3, 1, 5, 0);
    run_pass(int'($urandom % 2), int'($urandom % 2), 0);

    // Spurious start/vld/filt_done must not change anything, timing included.
    set_knobs(0, 0, 1, 1);
    s = int'($urandom % 2);
    run_pass(s, 1 - s, 1);

    // Reset during LOAD of sub-block 5, then a clean pass.
    set_knobs(0, 0, 1, 0);
    start_pass(int'(MC_CHROMA_CR), int'(MC_CHROMA_CR), 1);
    for (int n = 0; n < LIM && hs_cnt < 6; n++) step();
    check("hs_reached", hs_cnt, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete(); done_q.delete();
    exp_busy = 0; hs_cnt = 0; filt_total = 0;
    check_reset_outputs("rst_mid");
    repeat (2) step();
    run_pass(int'(MC_CHROMA_CB), int'(MC_CHROMA_CB), 1);

    // Randomized timing passes.
    for (int p = 0; p < 2; p++) begin
      set_knobs(int'($urandom_range(0, 4)), 2, int'($urandom_range(1, 6)), int'($urandom % 2));
      run_pass(int'($urandom % 2), int'($urandom % 2), 0);
    end

    // Back-to-back Cb then Cr, second start three cycles after done.
    set_knobs(0, 0, 1, 0);
    start_pass(int'(MC_CHROMA_CB), int'(MC_CHROMA_CB), 1);
    wait_done();
    repeat (2) step();
    start_pass(int'(MC_CHROMA_CR), int'(MC_CHROMA_CB), 1);
    wait_done();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
